// File: rtl/bitwise_rtp_module_if.sv
// Bus between a packet source/sink and the serial-to-RTP packetiser.
// The master side supplies packet parameters and payload bits; the slave
// side (the packetiser) returns RTP bytes and payload flow control.
interface bitwise_rtp_module_if;
    logic        data_in;
    logic        data_valid_in;
    logic        prepare_for_data;
    logic [15:0] payload_size;
    logic [31:0] rtp_timestamp;
    logic        rtp_marker_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_for_data;
    logic [15:0] bit_counter;

    modport master (
        output data_in, data_valid_in, prepare_for_data,
               payload_size, rtp_timestamp, rtp_marker_in,
        input  data_out, valid_out, ready_for_data, bit_counter
    );

    modport slave (
        input  data_in, data_valid_in, prepare_for_data,
               payload_size, rtp_timestamp, rtp_marker_in,
        output data_out, valid_out, ready_for_data, bit_counter
    );
endinterface

// File: rtl/bitwise_rtp_module.sv
// Serial-to-RTP packetiser: emits a 12-byte RTP header, then packs
// MSB-first serial payload bits into bytes, padding a trailing partial
// byte with zeros in its low bits.
module bitwise_rtp_module #(
    parameter logic [6:0]  PAYLOAD_TYPE = 7'd96,
    parameter logic [31:0] SSRC         = 32'h1234_5678,
    parameter logic [15:0] SEQ_INIT     = 16'd0
) (
    input logic                   clk_in,
    input logic                   rst_in,
    bitwise_rtp_module_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t      state;
    logic [3:0]  hdr_idx;
    logic [15:0] seq;
    logic [15:0] size_q;
    logic [31:0] ts_q;
    logic        marker_q;
    logic [7:0]  assembler;

    logic [7:0]  hdr_byte;
    logic [7:0]  asm_next;
    logic [15:0] count_next;
    logic [7:0]  partial_byte;

    // Header byte selected by position; byte 0 is issued directly from IDLE
    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            4'd0:  hdr_byte = 8'h80;
            4'd1:  hdr_byte = {marker_q, PAYLOAD_TYPE};
            4'd2:  hdr_byte = seq[15:8];
            4'd3:  hdr_byte = seq[7:0];
            4'd4:  hdr_byte = ts_q[31:24];
            4'd5:  hdr_byte = ts_q[23:16];
            4'd6:  hdr_byte = ts_q[15:8];
            4'd7:  hdr_byte = ts_q[7:0];
            4'd8:  hdr_byte = SSRC[31:24];
            4'd9:  hdr_byte = SSRC[23:16];
            4'd10: hdr_byte = SSRC[15:8];
            4'd11: hdr_byte = SSRC[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Next assembler contents and bit count if the current bit is accepted;
    // a trailing partial byte is shifted up so its first bit lands in bit 7
    always_comb begin
        asm_next     = {assembler[6:0], bus.data_in};
        count_next   = bus.bit_counter + 16'd1;
        partial_byte = asm_next << (4'd8 - {1'b0, count_next[2:0]});
    end

    // Packet sequencer: header emission, payload packing and sequence numbering
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            hdr_idx            <= 4'd0;
            seq                <= SEQ_INIT;
            size_q             <= 16'd0;
            ts_q               <= 32'd0;
            marker_q           <= 1'b0;
            assembler          <= 8'd0;
            bus.data_out       <= 8'd0;
            bus.valid_out      <= 1'b0;
            bus.ready_for_data <= 1'b0;
            bus.bit_counter    <= 16'd0;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.prepare_for_data) begin
                        size_q          <= bus.payload_size;
                        ts_q            <= bus.rtp_timestamp;
                        marker_q        <= bus.rtp_marker_in;
                        bus.bit_counter <= 16'd0;
                        assembler       <= 8'd0;
                        bus.data_out    <= 8'h80;
                        bus.valid_out   <= 1'b1;
                        hdr_idx         <= 4'd1;
                        state           <= HEADER;
                    end
                end
                HEADER: begin
                    bus.data_out  <= hdr_byte;
                    bus.valid_out <= 1'b1;
                    if (hdr_idx == 4'd11) begin
                        hdr_idx <= 4'd0;
                        if (size_q == 16'd0) begin
                            seq   <= seq + 16'd1;
                            state <= IDLE;
                        end else begin
                            bus.ready_for_data <= 1'b1;
                            state              <= PAYLOAD;
                        end
                    end else begin
                        hdr_idx <= hdr_idx + 4'd1;
                    end
                end
                PAYLOAD: begin
                    if (bus.data_valid_in) begin
                        bus.bit_counter <= count_next;
                        if (count_next == size_q) begin
                            bus.data_out       <= (count_next[2:0] == 3'd0) ? asm_next : partial_byte;
                            bus.valid_out      <= 1'b1;
                            assembler          <= 8'd0;
                            bus.ready_for_data <= 1'b0;
                            seq                <= seq + 16'd1;
                            state              <= IDLE;
                        end else if (count_next[2:0] == 3'd0) begin
                            bus.data_out  <= asm_next;
                            bus.valid_out <= 1'b1;
                            assembler     <= 8'd0;
                        end else begin
                            assembler <= asm_next;
                        end
                    end
                end
                default: begin
                    bus.ready_for_data <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_rtp_module.sv
// Self-checking bench for the serial-to-RTP packetiser. Expected byte
// streams are built from packet parameters and the payload bit list.
module tb_bitwise_rtp_module;

    logic clk_in = 1'b0;
    logic rst_in;

    always #5 clk_in = ~clk_in;

    bitwise_rtp_module_if bus();

    bitwise_rtp_module dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [7:0]  got[$];
    int          got_cyc[$];
    logic [7:0]  exp_bytes[$];
    logic        pbits[$];
    logic [15:0] exp_seq;

    // Free-running cycle number for timing checks
    always @(posedge clk_in) cycle++;

    // Capture every emitted byte with the cycle it appeared in
    always @(negedge clk_in) begin
        if (!rst_in && bus.valid_out) begin
            got.push_back(bus.data_out);
            got_cyc.push_back(cycle);
        end
    end

    // Append the bytes one packet should produce: header then packed payload
    task automatic build_expected(input int size, input logic [31:0] ts,
                                  input logic marker, input logic [15:0] seq);
        logic [7:0]  b;
        logic [31:0] ssrc;
        ssrc = 32'h1234_5678;
        exp_bytes.push_back(8'h80);
        exp_bytes.push_back({marker, 7'd96});
        exp_bytes.push_back(seq[15:8]);
        exp_bytes.push_back(seq[7:0]);
        for (int k = 3; k >= 0; k--) exp_bytes.push_back(8'((ts >> (8 * k)) & 32'hFF));
        for (int k = 3; k >= 0; k--) exp_bytes.push_back(8'((ssrc >> (8 * k)) & 32'hFF));
        for (int n = 0; n < (size + 7) / 8; n++) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++)
                if (8 * n + k < size) b[7 - k] = pbits[8 * n + k];
            exp_bytes.push_back(b);
        end
    endtask

    task automatic fill_random(input int size);
        pbits.delete();
        for (int i = 0; i < size; i++) pbits.push_back(1'($urandom_range(0, 1)));
    endtask

    // Start a packet and feed pbits with random data_valid_in gaps
    task automatic send_packet(input int size, input logic [31:0] ts,
                               input logic marker, input int gap_pct);
        int waited;
        int sent;
        int budget;
        got.delete();
        got_cyc.delete();
        exp_bytes.delete();
        build_expected(size, ts, marker, exp_seq);
        @(negedge clk_in);
        bus.payload_size     = 16'(size);
        bus.rtp_timestamp    = ts;
        bus.rtp_marker_in    = marker;
        bus.prepare_for_data = 1'b1;
        @(negedge clk_in);
        bus.prepare_for_data = 1'b0;
        bus.payload_size     = 16'($urandom);
        bus.rtp_timestamp    = $urandom;
        bus.rtp_marker_in    = 1'($urandom_range(0, 1));
        if (size == 0) begin
            repeat (14) @(negedge clk_in);
        end else begin
            waited = 0;
            while (!bus.ready_for_data && waited < 40) begin
                @(negedge clk_in);
                waited++;
            end
            if (!bus.ready_for_data) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout ready_for_data=%0b required 1", bus.ready_for_data);
            end else begin
                sent   = 0;
                budget = 0;
                while (sent < size && budget < 3000) begin
                    if ($urandom_range(0, 99) < gap_pct) begin
                        bus.data_valid_in = 1'b0;
                        bus.data_in       = 1'($urandom_range(0, 1));
                    end else begin
                        bus.data_valid_in = 1'b1;
                        bus.data_in       = pbits[sent];
                        sent++;
                    end
                    @(negedge clk_in);
                    budget++;
                end
                bus.data_valid_in = 1'b0;
                repeat (3) @(negedge clk_in);
            end
        end
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        bus.data_in = 1'b0;
        bus.data_valid_in = 1'b0;
        bus.prepare_for_data = 1'b0;
        bus.payload_size = 16'd0;
        bus.rtp_timestamp = 32'd0;
        bus.rtp_marker_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %02h expected 00", bus.data_out); end
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", bus.valid_out); end
        checks++;
        if (bus.ready_for_data !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b expected 0", bus.ready_for_data); end
        checks++;
        if (bus.bit_counter !== 16'd0) begin errors++; $display("FAIL reset_bit_counter got %0d expected 0", bus.bit_counter); end
        rst_in  = 1'b0;
        exp_seq = 16'd0;
    endtask

    task automatic test_header_payload;
        logic [15:0] fixed_bits;
        fixed_bits = 16'b1010_1101_1110_1111;
        pbits.delete();
        for (int i = 15; i >= 0; i--) pbits.push_back(fixed_bits[i]);
        send_packet(16, 32'd200, 1'b1, 0);
        checks++;
        if (got.size() !== exp_bytes.size()) begin errors++; $display("FAIL hp_count got %0d expected %0d", got.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL hp_byte%0d got %02h expected %02h", i, got[i], exp_bytes[i]); end
        end
        if (got.size() >= 14) begin
            checks++;
            if (got[1] !== 8'hE0 || got[7] !== 8'hC8 || got[12] !== 8'hAD || got[13] !== 8'hEF) begin
                errors++;
                $display("FAIL hp_known got %02h %02h %02h %02h expected e0 c8 ad ef", got[1], got[7], got[12], got[13]);
            end
            checks++;
            if (got_cyc[11] - got_cyc[0] !== 11) begin errors++; $display("FAIL hp_header_span got %0d expected 11", got_cyc[11] - got_cyc[0]); end
        end
        checks++;
        if (bus.bit_counter !== 16'd16) begin errors++; $display("FAIL hp_bit_counter got %0d expected 16", bus.bit_counter); end
        checks++;
        if (bus.ready_for_data !== 1'b0) begin errors++; $display("FAIL hp_ready_after got %0b expected 0", bus.ready_for_data); end
        checks++;
        if (bus.data_out !== 8'hEF || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL hp_hold got %02h/%0b expected ef/0", bus.data_out, bus.valid_out);
        end
    endtask

    task automatic test_second_packet;
        fill_random(8);
        send_packet(8, 32'hDEAD_BEEF, 1'b0, 20);
        checks++;
        if (got.size() !== exp_bytes.size()) begin errors++; $display("FAIL second_count got %0d expected %0d", got.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL second_byte%0d got %02h expected %02h", i, got[i], exp_bytes[i]); end
        end
        if (got.size() >= 4) begin
            checks++;
            if (got[1] !== 8'h60 || got[2] !== 8'h00 || got[3] !== 8'h01) begin
                errors++;
                $display("FAIL second_hdr got %02h %02h %02h expected 60 00 01", got[1], got[2], got[3]);
            end
        end
    endtask

    task automatic test_stall;
        fill_random(24);
        send_packet(24, $urandom, 1'b1, 60);
        checks++;
        if (got.size() !== exp_bytes.size()) begin errors++; $display("FAIL stall_count got %0d expected %0d", got.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL stall_byte%0d got %02h expected %02h", i, got[i], exp_bytes[i]); end
        end
    endtask

    task automatic test_partial;
        fill_random(12);
        send_packet(12, $urandom, 1'b0, 10);
        checks++;
        if (got.size() !== exp_bytes.size()) begin errors++; $display("FAIL partial_count got %0d expected %0d", got.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL partial_byte%0d got %02h expected %02h", i, got[i], exp_bytes[i]); end
        end
        if (got.size() >= 14) begin
            checks++;
            if (got[13][3:0] !== 4'h0) begin errors++; $display("FAIL partial_pad got %01h expected 0", got[13][3:0]); end
        end
        checks++;
        if (bus.bit_counter !== 16'd12) begin errors++; $display("FAIL partial_bit_counter got %0d expected 12", bus.bit_counter); end
    endtask

    // prepare_for_data held high across a whole zero-length packet
    task automatic test_back_to_back;
        logic [31:0] ts;
        ts = $urandom;
        got.delete();
        got_cyc.delete();
        exp_bytes.delete();
        pbits.delete();
        build_expected(0, ts, 1'b1, exp_seq);
        build_expected(0, ts, 1'b1, exp_seq + 16'd1);
        @(negedge clk_in);
        bus.payload_size     = 16'd0;
        bus.rtp_timestamp    = ts;
        bus.rtp_marker_in    = 1'b1;
        bus.prepare_for_data = 1'b1;
        repeat (13) @(negedge clk_in);
        bus.prepare_for_data = 1'b0;
        repeat (16) @(negedge clk_in);
        exp_seq = exp_seq + 16'd2;
        checks++;
        if (got.size() !== exp_bytes.size()) begin errors++; $display("FAIL b2b_count got %0d expected %0d", got.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL b2b_byte%0d got %02h expected %02h", i, got[i], exp_bytes[i]); end
        end
        if (got.size() >= 24) begin
            checks++;
            if (got_cyc[23] - got_cyc[0] !== 23) begin errors++; $display("FAIL b2b_span got %0d expected 23", got_cyc[23] - got_cyc[0]); end
        end
    endtask

    task automatic test_random;
        int size;
        for (int p = 0; p < 6; p++) begin
            size = $urandom_range(0, 40);
            fill_random(size);
            send_packet(size, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 50));
            checks++;
            if (got.size() !== exp_bytes.size()) begin errors++; $display("FAIL rand%0d_count got %0d expected %0d", p, got.size(), exp_bytes.size()); end
            for (int i = 0; i < exp_bytes.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL rand%0d_byte%0d got %02h expected %02h", p, i, got[i], exp_bytes[i]); end
            end
            checks++;
            if (bus.bit_counter !== 16'(size)) begin errors++; $display("FAIL rand%0d_bit_counter got %0d expected %0d", p, bus.bit_counter, size); end
        end
    endtask

    task automatic test_reset_mid_payload;
        int waited;
        got.delete();
        got_cyc.delete();
        exp_bytes.delete();
        fill_random(32);
        build_expected(32, 32'h0102_0304, 1'b0, exp_seq);
        @(negedge clk_in);
        bus.payload_size     = 16'd32;
        bus.rtp_timestamp    = 32'h0102_0304;
        bus.rtp_marker_in    = 1'b0;
        bus.prepare_for_data = 1'b1;
        @(negedge clk_in);
        bus.prepare_for_data = 1'b0;
        waited = 0;
        while (!bus.ready_for_data && waited < 40) begin
            @(negedge clk_in);
            waited++;
        end
        checks++;
        if (bus.ready_for_data !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %0b expected 1", bus.ready_for_data); end
        for (int i = 0; i < 10; i++) begin
            bus.data_valid_in = 1'b1;
            bus.data_in       = pbits[i];
            @(negedge clk_in);
        end
        bus.data_valid_in = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.valid_out !== 1'b0 || bus.ready_for_data !== 1'b0 || bus.bit_counter !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %02h/%0b/%0b/%0d expected 00/0/0/0",
                     bus.data_out, bus.valid_out, bus.ready_for_data, bus.bit_counter);
        end
        checks++;
        if (got.size() !== 13) begin
            errors++;
            $display("FAIL rst_mid_count got %0d expected 13", got.size());
        end else begin
            checks++;
            if (got[12] !== exp_bytes[12]) begin errors++; $display("FAIL rst_mid_first_byte got %02h expected %02h", got[12], exp_bytes[12]); end
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (got.size() !== 13) begin errors++; $display("FAIL rst_mid_quiet got %0d expected 13", got.size()); end
        exp_seq = 16'd0;
        fill_random(8);
        send_packet(8, $urandom, 1'b1, 0);
        checks++;
        if (got.size() !== exp_bytes.size()) begin errors++; $display("FAIL rst_after_count got %0d expected %0d", got.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL rst_after_byte%0d got %02h expected %02h", i, got[i], exp_bytes[i]); end
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_header_payload();
        test_second_packet();
        test_stall();
        test_partial();
        test_back_to_back();
        test_random();
        test_reset_mid_payload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
